// File: rtl/seg_display_arbiter.sv
// Round-robin time-slicing arbiter that shares one 4-digit seven-segment display
// among NUM_REQ requesters.
//
// Each owner keeps the display for DWELL_CYCLES clocks. HEX follows the owner's live
// data with a one-cycle latency.
//
// Optional feature, enabled by defining the macro DISP_ARB_LOCK_EN:
//   lock_i[owner] extends the window past the dwell time. Without the macro, lock_i
//   is ignored.
module seg_display_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DWELL_CYCLES = 100_000_000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [16*NUM_REQ-1:0]      data_i,
    input  logic [NUM_REQ-1:0]         lock_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [15:0]                hex_o,
    output logic                       valid_o,
    output logic [$clog2(NUM_REQ)-1:0] src_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(DWELL_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL_CYCLES - 1);
    localparam logic [IdxW-1:0] PtrRst  = IdxW'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StShow} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [15:0]         hex_q, hex_d;
    logic                valid_q, valid_d;
    logic [IdxW-1:0]     src_q, src_d;
    // Last owner; doubles as the current owner while in StShow.
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [15:0]         data_arr [NUM_REQ];
    logic                arb_found;
    logic [IdxW-1:0]     arb_idx;
    logic [IdxW-1:0]     arb_cand;
    logic                lock_hold;

    // Unpack the flat data bus into one word per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign data_arr[g] = data_i[16*g +: 16];
    end

`ifdef DISP_ARB_LOCK_EN
    assign lock_hold = lock_i[ptr_q];
`else
    logic unused_lock;
    assign unused_lock = ^lock_i;
    assign lock_hold   = 1'b0;
`endif

    // First requester after the pointer, wrapping around (pointer itself is checked last).
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            arb_cand = IdxW'((int'(ptr_q) + k) % int'(NUM_REQ));
            if (req_i[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        hex_d   = hex_q;
        valid_d = valid_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    state_d        = StShow;
                    gnt_d          = '0;
                    gnt_d[arb_idx] = 1'b1;
                    src_d          = arb_idx;
                    ptr_d          = arb_idx;
                    valid_d        = 1'b1;
                    hex_d          = data_arr[arb_idx];
                    cnt_d          = '0;
                end
            end
            StShow: begin
                if (!req_i[ptr_q] || (cnt_q == CntLast && !lock_hold)) begin
                    // Owner dropped or window expired; arb may re-pick the owner.
                    if (arb_found) begin
                        gnt_d          = '0;
                        gnt_d[arb_idx] = 1'b1;
                        src_d          = arb_idx;
                        ptr_d          = arb_idx;
                        hex_d          = data_arr[arb_idx];
                        cnt_d          = '0;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end else begin
                    hex_d = data_arr[ptr_q];
                    if (cnt_q != CntLast) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            hex_q   <= 16'h0000;
            valid_q <= 1'b0;
            src_q   <= '0;
            ptr_q   <= PtrRst;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign hex_o   = hex_q;
    assign valid_o = valid_q;
    assign src_o   = src_q;

endmodule
